// File: rtl/rmac_frame_parser_pkg.sv
// Shared constants, SIGNAL word layout and helper functions for the receive-side MAC deframer.
package rmac_frame_parser_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SIG  = 2'd1;
    localparam logic [1:0] ST_CHK  = 2'd2;
    localparam logic [1:0] ST_PLD  = 2'd3;

    localparam int unsigned SIG_W        = 32'd24;
    localparam int unsigned SIG_RATE_LSB = 32'd0;
    localparam int unsigned SIG_RSVD_BIT = 32'd4;
    localparam int unsigned SIG_LEN_LSB  = 32'd5;
    localparam int unsigned SIG_LEN_W    = 32'd12;
    localparam int unsigned SIG_PAR_BIT  = 32'd17;
    localparam int unsigned SIG_TAIL_LSB = 32'd18;

    localparam logic [3:0] RATE_T0 = 4'b1101;
    localparam logic [3:0] RATE_T1 = 4'b1111;
    localparam logic [3:0] RATE_T2 = 4'b0101;
    localparam logic [3:0] RATE_T3 = 4'b0111;
    localparam logic [3:0] RATE_T4 = 4'b1001;
    localparam logic [3:0] RATE_T5 = 4'b1011;
    localparam logic [3:0] RATE_T6 = 4'b0001;
    localparam logic [3:0] RATE_T7 = 4'b0011;

    localparam int unsigned DEF_MAX_LEN = 32'd4095;
    localparam int unsigned DEF_TIMEOUT = 32'd1024;

    // Field view of the SIGNAL word, most significant field first.
    typedef struct packed {
        logic [5:0]  tail;
        logic        parity;
        logic [11:0] len;
        logic        rsvd;
        logic [3:0]  rate;
    } sig_word_t;

    function automatic logic even_parity_ok(input logic [17:0] v);
        return ~(^v);
    endfunction

    // Returns {valid, type[2:0]} for a RATE nibble.
    function automatic logic [3:0] rate_lookup(input logic [3:0] rate);
        logic [3:0] r;
        case (rate)
            RATE_T0: r = 4'b1_000;
            RATE_T1: r = 4'b1_001;
            RATE_T2: r = 4'b1_010;
            RATE_T3: r = 4'b1_011;
            RATE_T4: r = 4'b1_100;
            RATE_T5: r = 4'b1_101;
            RATE_T6: r = 4'b1_110;
            RATE_T7: r = 4'b1_111;
            default: r = 4'b0_000;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rmac_sig_decode.sv
// Combinational SIGNAL-field checker: validates RATE, reserved bit, parity, tail and LENGTH range.
module rmac_sig_decode
    import rmac_frame_parser_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN
) (
    input  logic [23:0] sig_word,
    output logic        ok,
    output logic [3:0]  sig_type,
    output logic [11:0] len
);

    sig_word_t  fields_s;
    logic [3:0] lookup_s;
    logic       len_ok_s;

    // Field extraction and pass/fail decision.
    always_comb begin
        fields_s = sig_word_t'(sig_word);
        lookup_s = rate_lookup(fields_s.rate);
        len      = fields_s.len;
        sig_type = {1'b0, lookup_s[2:0]};
        len_ok_s = (fields_s.len != 12'd0) && ({20'd0, fields_s.len} <= MAX_LEN);
        ok       = lookup_s[3] && (fields_s.rsvd == 1'b0) && even_parity_ok(sig_word[17:0])
                   && (fields_s.tail == 6'd0) && len_ok_s;
    end

endmodule

// File: rtl/rmac_frame_parser.sv
// Receive MAC deframer: SIGNAL capture/check FSM, LSB-first byte packer and event counters.
// Define RMAC_STATS_EN to build the good/bad frame counters; otherwise both ports read 0.
module rmac_frame_parser
    import rmac_frame_parser_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        di_signal,
    input  logic        di_signal_vld,
    input  logic        di_payload,
    input  logic        di_payload_vld,
    output logic        frame_new,
    output logic [15:0] frame_len,
    output logic [3:0]  frame_type,
    output logic [7:0]  byte_out,
    output logic        byte_vld,
    output logic        frame_vld,
    output logic        sig_err,
    output logic        pld_err,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);

    localparam int unsigned IDLE_W = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 32'd1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 32'd1);
    localparam logic [4:0] SIG_LAST = 5'(SIG_W - 32'd1);

    logic [1:0]        state_r, state_s;
    logic [23:0]       sig_r, sig_s, sig_shift_s, sig_first_s;
    logic [4:0]        bit_cnt_r, bit_cnt_s;
    logic [11:0]       byte_cnt_r, byte_cnt_s;
    logic [IDLE_W-1:0] idle_cnt_r, idle_cnt_s;
    logic [2:0]        pbit_cnt_r, pbit_cnt_s;
    logic [7:0]        pack_r, pack_s, pack_next_s;
    logic              chk_ok_r, chk_ok_s;
    logic              frame_new_s, byte_vld_s, frame_vld_s, sig_err_s, pld_err_s;
    logic [15:0]       frame_len_s;
    logic [3:0]        frame_type_s;
    logic [7:0]        byte_out_s;
    logic              dec_ok_s;
    logic [3:0]        dec_type_s;
    logic [11:0]       dec_len_s;

    // Word as it will look once the current SIGNAL bit is stored; the decoder checks this
    // so the verdict is registered on the same edge that samples the 24th bit.
    always_comb begin
        sig_shift_s            = sig_r;
        sig_shift_s[bit_cnt_r] = di_signal;
        sig_first_s            = {23'd0, di_signal};
        pack_next_s            = {di_payload, pack_r[7:1]};
    end

    rmac_sig_decode #(
        .MAX_LEN (MAX_LEN)
    ) u_sig_decode (
        .sig_word (sig_shift_s),
        .ok       (dec_ok_s),
        .sig_type (dec_type_s),
        .len      (dec_len_s)
    );

    // Next-state and next-output logic for the deframer FSM.
    always_comb begin
        state_s      = state_r;
        sig_s        = sig_r;
        bit_cnt_s    = bit_cnt_r;
        byte_cnt_s   = byte_cnt_r;
        idle_cnt_s   = idle_cnt_r;
        pbit_cnt_s   = pbit_cnt_r;
        pack_s       = pack_r;
        chk_ok_s     = chk_ok_r;
        frame_len_s  = frame_len;
        frame_type_s = frame_type;
        byte_out_s   = byte_out;
        frame_new_s  = 1'b0;
        byte_vld_s   = 1'b0;
        frame_vld_s  = 1'b0;
        sig_err_s    = 1'b0;
        pld_err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (di_signal_vld) begin
                    sig_s     = sig_first_s;
                    bit_cnt_s = 5'd1;
                    state_s   = ST_SIG;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SIG: begin
                if (di_signal_vld) begin
                    sig_s = sig_shift_s;
                    if (bit_cnt_r == SIG_LAST) begin
                        bit_cnt_s = 5'd0;
                        state_s   = ST_CHK;
                        chk_ok_s  = dec_ok_s;
                        if (dec_ok_s) begin
                            frame_new_s  = 1'b1;
                            frame_len_s  = {4'd0, dec_len_s};
                            frame_type_s = dec_type_s;
                        end else begin
                            sig_err_s = 1'b1;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r + 5'd1;
                    end
                end else begin
                    state_s = ST_SIG;
                end
            end
            ST_CHK: begin
                byte_cnt_s = 12'd0;
                idle_cnt_s = '0;
                pbit_cnt_s = 3'd0;
                pack_s     = 8'd0;
                if (chk_ok_r) begin
                    state_s = ST_PLD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PLD: begin
                if (di_signal_vld) begin
                    // A new SIGNAL pre-empts the payload; its first bit is kept.
                    pld_err_s = 1'b1;
                    sig_s     = sig_first_s;
                    bit_cnt_s = 5'd1;
                    state_s   = ST_SIG;
                end else if (di_payload_vld) begin
                    idle_cnt_s = '0;
                    pack_s     = pack_next_s;
                    pbit_cnt_s = pbit_cnt_r + 3'd1;
                    if (pbit_cnt_r == 3'd7) begin
                        byte_out_s = pack_next_s;
                        byte_vld_s = 1'b1;
                        byte_cnt_s = byte_cnt_r + 12'd1;
                        if ((byte_cnt_r + 12'd1) == frame_len[11:0]) begin
                            frame_vld_s = 1'b1;
                            state_s     = ST_IDLE;
                        end else begin
                            state_s = ST_PLD;
                        end
                    end else begin
                        byte_vld_s = 1'b0;
                    end
                end else if (idle_cnt_r == IDLE_LAST) begin
                    pld_err_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    idle_cnt_s = idle_cnt_r + 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            sig_r      <= 24'd0;
            bit_cnt_r  <= 5'd0;
            byte_cnt_r <= 12'd0;
            idle_cnt_r <= '0;
            pbit_cnt_r <= 3'd0;
            pack_r     <= 8'd0;
            chk_ok_r   <= 1'b0;
            frame_new  <= 1'b0;
            frame_len  <= 16'd0;
            frame_type <= 4'd0;
            byte_out   <= 8'd0;
            byte_vld   <= 1'b0;
            frame_vld  <= 1'b0;
            sig_err    <= 1'b0;
            pld_err    <= 1'b0;
        end else begin
            state_r    <= state_s;
            sig_r      <= sig_s;
            bit_cnt_r  <= bit_cnt_s;
            byte_cnt_r <= byte_cnt_s;
            idle_cnt_r <= idle_cnt_s;
            pbit_cnt_r <= pbit_cnt_s;
            pack_r     <= pack_s;
            chk_ok_r   <= chk_ok_s;
            frame_new  <= frame_new_s;
            frame_len  <= frame_len_s;
            frame_type <= frame_type_s;
            byte_out   <= byte_out_s;
            byte_vld   <= byte_vld_s;
            frame_vld  <= frame_vld_s;
            sig_err    <= sig_err_s;
            pld_err    <= pld_err_s;
        end
    end

`ifdef RMAC_STATS_EN
    // Saturating event counters, updated on the same edge as their pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt <= 16'd0;
            bad_cnt  <= 16'd0;
        end else begin
            if (frame_vld_s) begin
                good_cnt <= sat_inc16(good_cnt);
            end
            if (sig_err_s || pld_err_s) begin
                bad_cnt <= sat_inc16(bad_cnt);
            end
        end
    end
`else
    assign good_cnt = 16'd0;
    assign bad_cnt  = 16'd0;
`endif

endmodule
